// File: rtl/pe_pkg.sv
// Shared defaults for the weight-stationary PE: operand/accumulator widths and bank depth.
package pe_pkg;

    localparam int PE_IFMAP_W  = 8;
    localparam int PE_WEIGHT_W = 8;
    localparam int PE_ACC_W    = 24;
    localparam int PE_NUM_K    = 4;

    localparam int PE_PROD_W   = PE_IFMAP_W + PE_WEIGHT_W;
    localparam int PE_KSEL_W   = $clog2(PE_NUM_K);

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_sel_e;

endpackage

// File: rtl/pe_weight_dbuf.sv
// Double-buffered weight store: two NUM_K-entry banks, one active for reads and one shadow for loads.
module pe_weight_dbuf
    import pe_pkg::*;
#(
    parameter int WEIGHT_W = PE_WEIGHT_W,
    parameter int NUM_K    = PE_NUM_K,
    localparam int K_W     = $clog2(NUM_K)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WEIGHT_W-1:0] weight_in,
    input  logic                weight_we,
    input  logic [K_W-1:0]      weight_addr,
    input  logic                weight_swap,
    input  logic [K_W-1:0]      rd_sel,
    output logic [WEIGHT_W-1:0] rd_weight
);

    bank_sel_e           bank_ptr_reg;
    bank_sel_e           bank_ptr_next;
    logic [WEIGHT_W-1:0] bank0 [NUM_K];
    logic [WEIGHT_W-1:0] bank1 [NUM_K];

    // Addresses with no matching entry (non-power-of-2 NUM_K) simply hit nothing.
    generate
        for (genvar gi = 0; gi < NUM_K; gi++) begin : g_entry
            logic                wr_hit;
            logic [WEIGHT_W-1:0] w0_reg;
            logic [WEIGHT_W-1:0] w1_reg;

            assign wr_hit = weight_we && (weight_addr == K_W'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    w0_reg <= '0;
                    w1_reg <= '0;
                end else if (wr_hit) begin
                    if (bank_ptr_reg == BANK_0) begin
                        w1_reg <= weight_in;
                    end else begin
                        w0_reg <= weight_in;
                    end
                end
            end

            assign bank0[gi] = w0_reg;
            assign bank1[gi] = w1_reg;
        end
    endgenerate

    always_comb begin
        bank_ptr_next = bank_ptr_reg;
        if (weight_swap) begin
            bank_ptr_next = (bank_ptr_reg == BANK_0) ? BANK_1 : BANK_0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_ptr_reg <= BANK_0;
        end else begin
            bank_ptr_reg <= bank_ptr_next;
        end
    end

    always_comb begin
        rd_weight = '0;
        for (int i = 0; i < NUM_K; i++) begin
            if (rd_sel == K_W'(i)) begin
                rd_weight = (bank_ptr_reg == BANK_0) ? bank0[i] : bank1[i];
            end
        end
    end

endmodule

// File: rtl/pe_mac_dbuf.sv
// Weight-stationary MAC PE with double-buffered weights, zero-skip and ifmap forwarding.
// Define PE_ACC_SAT_EN for saturating accumulation and the psum_sat output.
module pe_mac_dbuf
    import pe_pkg::*;
#(
    parameter int IFMAP_W  = PE_IFMAP_W,
    parameter int WEIGHT_W = PE_WEIGHT_W,
    parameter int ACC_W    = PE_ACC_W,
    parameter int NUM_K    = PE_NUM_K,
    localparam int PROD_W  = IFMAP_W + WEIGHT_W,
    localparam int K_W     = $clog2(NUM_K)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [IFMAP_W-1:0]  ifmap_in,
    input  logic                ifmap_valid_in,
    input  logic [K_W-1:0]      k_sel,
    input  logic                acc_last,
    input  logic                signed_mode,
    input  logic [WEIGHT_W-1:0] weight_in,
    input  logic                weight_we,
    input  logic [K_W-1:0]      weight_addr,
    input  logic                weight_swap,
    output logic [IFMAP_W-1:0]  ifmap_out,
    output logic                ifmap_valid_out,
    output logic [ACC_W-1:0]    psum_out,
`ifdef PE_ACC_SAT_EN
    output logic                psum_sat,
`endif
    output logic                psum_valid
);

    logic [WEIGHT_W-1:0] active_weight;

    pe_weight_dbuf #(
        .WEIGHT_W (WEIGHT_W),
        .NUM_K    (NUM_K)
    ) u_wbuf (
        .clk         (clk),
        .reset       (reset),
        .weight_in   (weight_in),
        .weight_we   (weight_we),
        .weight_addr (weight_addr),
        .weight_swap (weight_swap),
        .rd_sel      (k_sel),
        .rd_weight   (active_weight)
    );

    logic                fire;
    logic                mul_active;
    logic [IFMAP_W-1:0]  mul_a;
    logic [WEIGHT_W-1:0] mul_b;
    logic [IFMAP_W-1:0]  mul_a_reg;
    logic [WEIGHT_W-1:0] mul_b_reg;
    logic signed [PROD_W-1:0] a_s, b_s, prod_s;
    logic [PROD_W-1:0]   a_u, b_u, prod_u;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    logic [IFMAP_W-1:0]  ifmap_out_reg;
    logic                ifmap_valid_out_reg;
    logic [ACC_W-1:0]    psum_out_reg;
    logic                psum_valid_reg;

    assign fire       = ifmap_valid_in & ~stall;
    assign mul_active = fire && (ifmap_in != '0) && (active_weight != '0);

    // Idle or zero-operand cycles replay the last operands so the multiplier does not toggle.
    assign mul_a = mul_active ? ifmap_in      : mul_a_reg;
    assign mul_b = mul_active ? active_weight : mul_b_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_a_reg <= '0;
            mul_b_reg <= '0;
        end else if (mul_active) begin
            mul_a_reg <= ifmap_in;
            mul_b_reg <= active_weight;
        end
    end

    assign a_s    = PROD_W'($signed(mul_a));
    assign b_s    = PROD_W'($signed(mul_b));
    assign prod_s = a_s * b_s;
    assign a_u    = PROD_W'(mul_a);
    assign b_u    = PROD_W'(mul_b);
    assign prod_u = a_u * b_u;

    always_comb begin
        prod_ext = '0;
        if (mul_active) begin
            prod_ext = signed_mode ? ACC_W'(prod_s) : ACC_W'(prod_u);
        end
    end

`ifdef PE_ACC_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           step_sat;
    logic           sat_seen_reg;
    logic           psum_sat_reg;

    // One guard bit tells whether the true sum left the representable range.
    always_comb begin
        if (signed_mode) begin
            sum_wide = {acc_reg[ACC_W-1], acc_reg} + {prod_ext[ACC_W-1], prod_ext};
        end else begin
            sum_wide = {1'b0, acc_reg} + {1'b0, prod_ext};
        end
        acc_next = sum_wide[ACC_W-1:0];
        step_sat = 1'b0;
        if (signed_mode) begin
            if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
                step_sat = 1'b1;
                acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (sum_wide[ACC_W]) begin
            step_sat = 1'b1;
            acc_next = '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_seen_reg <= 1'b0;
            psum_sat_reg <= 1'b0;
        end else if (fire) begin
            if (acc_last) begin
                psum_sat_reg <= sat_seen_reg | step_sat;
                sat_seen_reg <= 1'b0;
            end else begin
                sat_seen_reg <= sat_seen_reg | step_sat;
            end
        end
    end

    assign psum_sat = psum_sat_reg & psum_valid_reg;
`else
    assign acc_next = acc_reg + prod_ext;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg             <= '0;
            ifmap_out_reg       <= '0;
            ifmap_valid_out_reg <= 1'b0;
            psum_out_reg        <= '0;
            psum_valid_reg      <= 1'b0;
        end else begin
            psum_valid_reg <= fire & acc_last;
            if (!stall) begin
                ifmap_valid_out_reg <= ifmap_valid_in;
                if (ifmap_valid_in) begin
                    ifmap_out_reg <= ifmap_in;
                end
            end
            if (fire) begin
                if (acc_last) begin
                    psum_out_reg <= acc_next;
                    acc_reg      <= '0;
                end else begin
                    acc_reg      <= acc_next;
                end
            end
        end
    end

    assign ifmap_out       = ifmap_out_reg;
    assign ifmap_valid_out = ifmap_valid_out_reg;
    assign psum_out        = psum_out_reg;
    assign psum_valid      = psum_valid_reg;

endmodule

// File: doc/pe_mac_dbuf.md
Name: pe_mac_dbuf

Overview:
- Parametrised weight-stationary processing element for the systolic array.
- Holds a double-buffered bank of NUM_K weights, so the next tile's weights load while the current tile computes.
- Multiplies a streaming ifmap by the selected weight, accumulates partial sums locally with signed/unsigned mode and zero-skip, and forwards the ifmap to the neighbouring PE with a valid bit and a global stall.

Parameters:
- IFMAP_W, 8, ifmap operand width
- WEIGHT_W, 8, weight operand width
- ACC_W, 24, accumulator/psum width; must be >= IFMAP_W+WEIGHT_W
- NUM_K, 4, weights per bank (kernels time-multiplexed per PE); must be >= 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  global hold: freezes the ifmap pipe and the accumulator
- ifmap_in  in  IFMAP_W  activation from the upstream PE or buffer
- ifmap_valid_in  in  1  ifmap_in is valid this cycle
- k_sel  in  $clog2(NUM_K)  active-bank weight index used for this ifmap
- acc_last  in  1  this valid ifmap is the last term of the current psum
- signed_mode  in  1  1 = both operands two's complement; 0 = unsigned
- weight_in  in  WEIGHT_W  weight load data
- weight_we  in  1  write weight_in into the shadow bank
- weight_addr  in  $clog2(NUM_K)  shadow-bank write index
- weight_swap  in  1  exchange the active and shadow banks
- ifmap_out  out  IFMAP_W  registered ifmap to the next PE
- ifmap_valid_out  out  1  registered valid to the next PE
- psum_out  out  ACC_W  completed partial sum
- psum_valid  out  1  one-cycle strobe; psum_out is valid

Behaviour:
- Reset (reset low, asynchronous): both banks, bank pointer, accumulator, ifmap_out, ifmap_valid_out, psum_out and psum_valid are all 0. Asserting reset mid-accumulation discards the partial sum. No psum_valid is emitted during or after reset.
- Define fire = ifmap_valid_in & !stall.
- Forwarding:
  - On fire: ifmap_out <= ifmap_in and ifmap_valid_out <= 1, one-cycle latency.
  - When !stall & !ifmap_valid_in: ifmap_valid_out <= 0 and ifmap_out holds its value.
  - When stall: ifmap_out and ifmap_valid_out hold.
- Product: prod = ifmap_in * active[k_sel], computed at full width IFMAP_W+WEIGHT_W, then sign-extended (signed_mode=1) or zero-extended to ACC_W.
  - Zero-skip: if either operand is 0, prod = 0 and the multiplier inputs are gated (held).
- Accumulate on fire:
  - acc_last=0: acc <= acc + prod.
  - acc_last=1: psum_out <= acc + prod, psum_valid <= 1, acc <= 0.
  - psum_valid is 0 in every other cycle, including stalled cycles. psum_out holds until the next completion.
- Stall: acc, k_sel effect and psum_valid are frozen or suppressed; ifmap_valid_in is ignored. Weight writes and swaps are still honoured during stall.
- Weight bank:
  - The shadow bank is written on weight_we at weight_addr.
  - weight_swap toggles the bank pointer at the clock edge; a product computed in that same cycle uses the pre-swap active bank.
  - weight_we together with weight_swap: the write lands in the pre-swap shadow bank, so it becomes active after the edge.
  - weight_addr >= NUM_K (non-power-of-2 NUM_K): the write is dropped.
- Arithmetic: accumulation wraps modulo 2^ACC_W unless PE_ACC_SAT_EN is defined. signed_mode must be constant for the whole psum; changing it mid-psum is undefined.

Optional Feature:
- PE_ACC_SAT_EN defined: every accumulate step, including the acc_last step, saturates.
  - signed_mode=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - signed_mode=0: clamp to [0, 2^ACC_W-1].
  - An extra output psum_sat (1 bit) is asserted together with psum_valid if any step of that psum saturated. Its reset value is 0.
- PE_ACC_SAT_EN undefined: modulo wrap, and the psum_sat port is absent.

Decomposition:
- pe_pkg holds: default widths (PE_IFMAP_W, PE_WEIGHT_W, PE_ACC_W, PE_NUM_K) and localparams for the product width and the k_sel width.
- Sub-module pe_weight_dbuf: two NUM_K x WEIGHT_W banks, bank pointer, shadow write port, swap, and active read port.
- The MAC, accumulator and forwarding logic stay in pe_mac_dbuf.

Test Plan:
- Reset, then load shadow {3,5,0,7}, swap, and stream ifmap 2 (k_sel=0), 4 (k_sel=1), 9 (k_sel=3, acc_last) -> psum_out=6+20+63=89, psum_valid for exactly one cycle; ifmap_out/ifmap_valid_out trail ifmap_in/ifmap_valid_in by 1 cycle.
- signed_mode=1, weight -3 (0xFD), ifmap -4 (0xFC), acc_last -> psum_out=12; the same bytes with signed_mode=0 give 253*252=63756.
- Stall held 3 cycles in the middle of a psum with ifmap_valid_in=1 -> ifmap_out, ifmap_valid_out and acc unchanged, no psum_valid; the sum equals the unstalled result.
- Load weights during compute, with weight_we and weight_swap in the same cycle at addr 2 value 9 -> the old bank is used up to the edge; after the swap, k_sel=2 multiplies by 9.
- Assert reset mid-psum (acc=50), release, stream ifmap 1 x weight 1 with acc_last -> psum_out=1.
- PE_ACC_SAT_EN, ACC_W=16, unsigned, stream 255*255 twice with acc_last -> psum_out=65535 and psum_sat=1; without the macro, psum_out=64514 (130050 mod 65536).
